// File: rtl/maze_step_engine.sv
`default_nettype none
// ============================================================================
// Module      : maze_step_engine
// Description : Grid-maze environment step engine. Turns (state, action) into
//               next state, reward and episode flags; blocked list scanned serially.
// Revision    : 1.0 - initial release
// ============================================================================
module maze_step_engine #(
    parameter int ROWS        = 6,
    parameter int COLS        = 6,
    parameter int NUM_BLOCKED = 16,
    parameter int MAX_STEPS   = 64,
    parameter int RW          = 16,
    parameter int REWARD_GOAL = 100,
    parameter int REWARD_STEP = -1,
    parameter int REWARD_WALL = -5,
    parameter int EW          = 16,
    parameter int N           = ROWS * COLS,
    parameter int SW          = $clog2(N + 1),
    parameter int CW          = $clog2(MAX_STEPS + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_BLOCKED*SW-1:0] blocked_flat,
    input  logic [SW-1:0]             target_state,
    input  logic [SW-1:0]             start_state,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [SW-1:0]             req_state,
    input  logic [3:0]                req_action,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [SW-1:0]             rsp_next_state,
    output logic signed [RW-1:0]      rsp_reward,
    output logic                      rsp_bumped,
    output logic                      rsp_done,
    output logic                      rsp_timeout,
    output logic [CW-1:0]             step_count,
    output logic [EW-1:0]             episode_count
);

    localparam int IW = $clog2(NUM_BLOCKED + 1);
    localparam int LW = (NUM_BLOCKED > 1) ? $clog2(NUM_BLOCKED) : 1;

    localparam logic [SW:0]          c_cols     = (SW+1)'(COLS);
    localparam logic [SW:0]          c_n        = (SW+1)'(N);
    localparam logic [SW:0]          c_one      = (SW+1)'(1);
    localparam logic [IW-1:0]        c_scan_end = IW'(NUM_BLOCKED);
    localparam logic [CW-1:0]        c_last     = CW'(MAX_STEPS - 1);
    localparam logic signed [RW-1:0] c_rw_goal  = RW'(REWARD_GOAL);
    localparam logic signed [RW-1:0] c_rw_step  = RW'(REWARD_STEP);
    localparam logic signed [RW-1:0] c_rw_wall  = RW'(REWARD_WALL);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_SCAN = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t r_fsm, w_fsm_nxt;

    logic [SW-1:0]  r_req_state;
    logic [3:0]     r_action;
    logic [SW:0]    r_cand;
    logic           r_edge;
    logic [IW-1:0]  r_idx;
    logic           r_hit;
    logic           r_blk;

    logic [SW:0]    w_s;
    logic [SW:0]    w_cand;
    logic           w_edge;
    int             w_mod;
    logic [SW-1:0]  w_list [NUM_BLOCKED];
    logic [LW-1:0]  w_sel;
    logic [SW-1:0]  w_entry;
    logic           w_hit;
    logic           w_blk;
    logic           w_scan_last;

    logic [SW-1:0]          w_next;
    logic signed [RW-1:0]   w_reward;
    logic                   w_bump;
    logic                   w_done;
    logic                   w_tout;
    logic                   w_count;

    assign req_ready = (r_fsm == S_IDLE);
    assign rsp_valid = (r_fsm == S_RESP);

    // ---------------- state register / next-state ----------------
    always_ff @(posedge clk) begin
        if (!rst) r_fsm <= S_IDLE;
        else      r_fsm <= w_fsm_nxt;
    end

    always_comb begin
        w_fsm_nxt = r_fsm;
        case (r_fsm)
            S_IDLE: if (req_valid) w_fsm_nxt = S_CALC;
            S_CALC: w_fsm_nxt = S_SCAN;
            S_SCAN: if (w_scan_last) w_fsm_nxt = S_RESP;
            S_RESP: if (rsp_ready) w_fsm_nxt = S_IDLE;
            default: w_fsm_nxt = S_IDLE;
        endcase
    end

    // ---------------- candidate and edge detection ----------------
    assign w_s   = {1'b0, r_req_state};
    assign w_mod = int'(r_req_state) % COLS;

    always_comb begin
        w_cand = w_s;
        w_edge = 1'b0;
        case (r_action)
            4'd0: begin
                w_cand = w_s + c_cols;
                w_edge = (w_s + c_cols) > c_n;
            end
            4'd1: begin
                w_cand = w_s + c_one;
                w_edge = (COLS == 1) || (w_mod == 0);
            end
            4'd2: begin
                w_cand = w_s - c_cols;
                w_edge = (w_s <= c_cols);
            end
            4'd3: begin
                w_cand = w_s - c_one;
                w_edge = (COLS == 1) || (w_mod == 1);
            end
            default: begin
                w_cand = w_s;
                w_edge = 1'b0;
            end
        endcase
    end

    // ---------------- blocked-list scan ----------------
    for (genvar gi = 0; gi < NUM_BLOCKED; gi++) begin : g_unpack
        assign w_list[gi] = blocked_flat[gi*SW +: SW];
    end

    // The compare result is registered, so the scan runs one drain cycle
    // past the last entry before the result is folded into the response.
    assign w_sel       = r_idx[LW-1:0];
    assign w_entry     = w_list[w_sel];
    assign w_hit       = (r_idx < c_scan_end) && (w_entry != '0) && ({1'b0, w_entry} == r_cand);
    assign w_blk       = r_blk | r_hit;
    assign w_scan_last = (r_idx == c_scan_end);

    // ---------------- result resolution ----------------
    always_comb begin
        w_next   = start_state;
        w_reward = '0;
        w_bump   = 1'b0;
        w_done   = 1'b0;
        w_tout   = 1'b0;
        w_count  = 1'b0;
        if ((r_req_state == '0) || (w_s > c_n)) begin
            w_next = start_state;
        end else if (r_req_state == target_state) begin
            w_next = start_state;
        end else begin
            w_count = 1'b1;
            if (r_action > 4'd3) begin
                w_next   = r_req_state;
                w_reward = c_rw_step;
            end else if (r_edge || w_blk) begin
                w_next   = r_req_state;
                w_reward = c_rw_wall;
                w_bump   = 1'b1;
            end else begin
                w_next = r_cand[SW-1:0];
                if (r_cand == {1'b0, target_state}) begin
                    w_reward = c_rw_goal;
                    w_done   = 1'b1;
                end else begin
                    w_reward = c_rw_step;
                end
            end
            w_tout = !w_done && (step_count == c_last);
        end
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_req_state    <= '0;
            r_action       <= '0;
            r_cand         <= '0;
            r_edge         <= 1'b0;
            r_idx          <= '0;
            r_hit          <= 1'b0;
            r_blk          <= 1'b0;
            rsp_next_state <= '0;
            rsp_reward     <= '0;
            rsp_bumped     <= 1'b0;
            rsp_done       <= 1'b0;
            rsp_timeout    <= 1'b0;
            step_count     <= '0;
            episode_count  <= '0;
        end else begin
            case (r_fsm)
                S_IDLE: begin
                    if (req_valid) begin
                        r_req_state <= req_state;
                        r_action    <= req_action;
                    end
                end
                S_CALC: begin
                    r_cand <= w_cand;
                    r_edge <= w_edge;
                    r_idx  <= '0;
                    r_hit  <= 1'b0;
                    r_blk  <= 1'b0;
                end
                S_SCAN: begin
                    if (w_scan_last) begin
                        rsp_next_state <= w_next;
                        rsp_reward     <= w_reward;
                        rsp_bumped     <= w_bump;
                        rsp_done       <= w_done;
                        rsp_timeout    <= w_tout;
                        if (w_count) begin
                            if (w_done || w_tout) begin
                                step_count    <= '0;
                                episode_count <= episode_count + 1'b1;
                            end else begin
                                step_count <= step_count + 1'b1;
                            end
                        end
                    end else begin
                        r_hit <= w_hit;
                        r_blk <= w_blk;
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_maze_step_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_maze_step_engine
// Description : Directed scoreboard bench for maze_step_engine (6x6, MAX_STEPS=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_maze_step_engine;

    localparam int NB = 16;
    localparam int SW = 6;
    localparam int CW = 3;
    localparam int EW = 16;
    localparam int LAT = NB + 2;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [NB*SW-1:0]  blocked_flat = '0;
    logic [SW-1:0]     target_state = 6'd36;
    logic [SW-1:0]     start_state  = 6'd1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [SW-1:0]     req_state = '0;
    logic [3:0]        req_action = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b1;
    logic [SW-1:0]     rsp_next_state;
    logic signed [15:0] rsp_reward;
    logic              rsp_bumped;
    logic              rsp_done;
    logic              rsp_timeout;
    logic [CW-1:0]     step_count;
    logic [EW-1:0]     episode_count;

    maze_step_engine #(
        .ROWS(6), .COLS(6), .NUM_BLOCKED(NB), .MAX_STEPS(4), .RW(16),
        .REWARD_GOAL(100), .REWARD_STEP(-1), .REWARD_WALL(-5), .EW(EW)
    ) dut (
        .clk(clk), .rst(rst), .blocked_flat(blocked_flat),
        .target_state(target_state), .start_state(start_state),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_state(req_state), .req_action(req_action),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_next_state(rsp_next_state), .rsp_reward(rsp_reward),
        .rsp_bumped(rsp_bumped), .rsp_done(rsp_done), .rsp_timeout(rsp_timeout),
        .step_count(step_count), .episode_count(episode_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int nxt; int rew; int b; int d; int t; int sc; int ep;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   last_acc = 0;
    bit   seen = 1'b0;
    exp_t e;

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Drive one request; waits (bounded) for the engine to be idle first.
    task automatic issue(input int s, input int a);
        int n;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) chk("req_ready_wait", 0, 1);
        req_valid  = 1'b1;
        req_state  = s[SW-1:0];
        req_action = a[3:0];
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        last_acc  = cyc;
    endtask

    task automatic send(input int s, input int a, input int nxt, input int rew,
                        input int b, input int d, input int t, input int sc, input int ep);
        exp_t x;
        x.nxt = nxt; x.rew = rew; x.b = b; x.d = d; x.t = t; x.sc = sc; x.ep = ep;
        q.push_back(x);
        issue(s, a);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((q.size() != 0 || !req_ready) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0 || !req_ready) chk("drain_timeout", q.size(), 0);
    endtask

    // Monitor: compares every accepted response against the scoreboard head.
    always @(negedge clk) begin
        if (rst && rsp_valid) begin
            if (!seen) begin
                seen = 1'b1;
                chk("latency", cyc - last_acc, LAT);
            end
            if (rsp_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_rsp", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("next_state", int'(rsp_next_state), e.nxt);
                    chk("reward", int'(rsp_reward), e.rew);
                    chk("bumped", int'(rsp_bumped), e.b);
                    chk("done", int'(rsp_done), e.d);
                    chk("timeout", int'(rsp_timeout), e.t);
                    chk("step_count", int'(step_count), e.sc);
                    chk("episode_count", int'(episode_count), e.ep);
                end
            end
        end else begin
            seen = 1'b0;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int saw;

        // Reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_rsp_valid", int'(rsp_valid), 0);
        chk("rst_next_state", int'(rsp_next_state), 0);
        chk("rst_reward", int'(rsp_reward), 0);
        chk("rst_step_count", int'(step_count), 0);
        chk("rst_episode_count", int'(episode_count), 0);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_req_ready", int'(req_ready), 1);

        // Legal move, edge bumps, timeout via bumps
        send(1, 0, 7, -1, 0, 0, 0, 1, 0);
        send(6, 1, 6, -5, 1, 0, 0, 2, 0);
        send(7, 3, 7, -5, 1, 0, 0, 3, 0);
        send(3, 2, 3, -5, 1, 0, 1, 0, 1);
        wait_drain();

        // Last-slot blocked hit, invalid action
        blocked_flat[15*SW +: SW] = 6'd8;
        send(2, 0, 2, -5, 1, 0, 0, 1, 1);
        send(2, 7, 2, -1, 0, 0, 0, 2, 1);
        wait_drain();
        blocked_flat = '0;

        // Goal, restart from target, invalid states
        send(30, 0, 36, 100, 0, 1, 0, 0, 2);
        send(36, 1, 1, 0, 0, 0, 0, 0, 2);
        send(0, 0, 1, 0, 0, 0, 0, 0, 2);
        send(37, 1, 1, 0, 0, 0, 0, 0, 2);

        // Step-limit timeout with back-pressure on the final response
        send(1, 1, 2, -1, 0, 0, 0, 1, 2);
        send(2, 1, 3, -1, 0, 0, 0, 2, 2);
        send(3, 1, 4, -1, 0, 0, 0, 3, 2);
        wait_drain();
        rsp_ready = 1'b0;
        send(4, 0, 10, -1, 0, 0, 1, 0, 3);
        n = 0;
        while (!rsp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("hold_rsp_seen", int'(rsp_valid), 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_valid", int'(rsp_valid), 1);
            chk("hold_next", int'(rsp_next_state), 10);
            chk("hold_timeout", int'(rsp_timeout), 1);
            chk("hold_req_ready", int'(req_ready), 0);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        wait_drain();

        // Reset during scan aborts the request
        issue(10, 0);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        saw = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (rsp_valid) saw = 1;
        end
        chk("abort_no_rsp", saw, 0);
        chk("abort_step_count", int'(step_count), 0);
        chk("abort_episode_count", int'(episode_count), 0);
        chk("abort_req_ready", int'(req_ready), 1);

        chk("scoreboard_empty", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
